// File: rtl/sc_scbc_rba.sv
// sc_scbc_rba: round-robin register bus arbiter for two masters with independent write and read channels
module sc_scbc_rba #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  SYSCLK,
  input  logic                  SYSRSTB,
  input  logic [ADDR_WIDTH-1:0] M0_WADR,
  input  logic [31:0]           M0_WDAT,
  input  logic [3:0]            M0_WENB,
  output logic                  M0_WWAT,
  output logic                  M0_WERR,
  input  logic [ADDR_WIDTH-1:0] M0_RADR,
  input  logic                  M0_RENB,
  output logic                  M0_RWAT,
  output logic [31:0]           M0_RDAT,
  output logic                  M0_RERR,
  input  logic [ADDR_WIDTH-1:0] M1_WADR,
  input  logic [31:0]           M1_WDAT,
  input  logic [3:0]            M1_WENB,
  output logic                  M1_WWAT,
  output logic                  M1_WERR,
  input  logic [ADDR_WIDTH-1:0] M1_RADR,
  input  logic                  M1_RENB,
  output logic                  M1_RWAT,
  output logic [31:0]           M1_RDAT,
  output logic                  M1_RERR,
  output logic [ADDR_WIDTH-1:0] S_WADR,
  output logic [31:0]           S_WDAT,
  output logic [3:0]            S_WENB,
  input  logic                  S_WWAT,
  input  logic                  S_WERR,
  output logic [ADDR_WIDTH-1:0] S_RADR,
  output logic                  S_RENB,
  input  logic                  S_RWAT,
  input  logic [31:0]           S_RDAT,
  input  logic                  S_RERR
);
  typedef enum logic {R_IDLE, R_WAIT} rstate_e;
  rstate_e               st_q, st_d;
  logic [1:0]            pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] padr0_q, padr0_d, padr1_q, padr1_d;
  logic                  own_q, own_d, rlast_q, rlast_d;
  logic                  wlock_q, wlock_d, wown_q, wown_d, wlast_q, wlast_d;
  logic                  wreq0, wreq1, wg, wact;
  logic                  c0, c1, sel, v0, v1, idle;
  // write grant: lock holds the owner through a stalled write, otherwise round-robin on ties
  always_comb begin
    wreq0 = SYSRSTB && (|M0_WENB);
    wreq1 = SYSRSTB && (|M1_WENB);
    wg = wlock_q ? wown_q : (wreq0 && wreq1) ? ~wlast_q : wreq1;
    wact = wg ? wreq1 : wreq0;
    S_WADR = wact ? (wg ? M1_WADR : M0_WADR) : '0;
    S_WDAT = wact ? (wg ? M1_WDAT : M0_WDAT) : '0;
    S_WENB = wact ? (wg ? M1_WENB : M0_WENB) : '0;
    M0_WWAT = wreq0 && (wg ? 1'b1 : S_WWAT);
    M1_WWAT = wreq1 && (wg ? S_WWAT : 1'b1);
    M0_WERR = wact && !wg && S_WERR;
    M1_WERR = wact && wg && S_WERR;
    wlock_d = wact && S_WWAT;
    wown_d = wg;
    wlast_d = (wact && !S_WWAT) ? wg : wlast_q;
  end
  // read FSM: issue from idle, track the owner until its data cycle, park other strobes in pend
  always_comb begin
    st_d = st_q;
    pend_d = pend_q;
    padr0_d = padr0_q;
    padr1_d = padr1_q;
    own_d = own_q;
    rlast_d = rlast_q;
    S_RENB = 1'b0;
    S_RADR = '0;
    M0_RWAT = pend_q[0];
    M1_RWAT = pend_q[1];
    M0_RDAT = '0;
    M1_RDAT = '0;
    M0_RERR = 1'b0;
    M1_RERR = 1'b0;
    idle = st_q == R_IDLE;
    c0 = SYSRSTB && (pend_q[0] || M0_RENB);
    c1 = SYSRSTB && (pend_q[1] || M1_RENB);
    sel = (c0 && c1) ? ~rlast_q : c1;
    v0 = SYSRSTB && M0_RENB && !pend_q[0] && (idle || own_q);
    v1 = SYSRSTB && M1_RENB && !pend_q[1] && (idle || !own_q);
    if (idle) begin
      if (c0 || c1) begin
        S_RENB = 1'b1;
        S_RADR = sel ? (pend_q[1] ? padr1_q : M1_RADR) : (pend_q[0] ? padr0_q : M0_RADR);
        st_d = R_WAIT;
        own_d = sel;
      end
    end else begin
      M0_RWAT = own_q ? pend_q[0] : S_RWAT;
      M1_RWAT = own_q ? S_RWAT : pend_q[1];
      if (!S_RWAT) begin
        M0_RDAT = own_q ? '0 : S_RDAT;
        M1_RDAT = own_q ? S_RDAT : '0;
        M0_RERR = !own_q && S_RERR;
        M1_RERR = own_q && S_RERR;
        st_d = R_IDLE;
        rlast_d = own_q;
      end
    end
    if (v0 && !(idle && !sel)) begin
      pend_d[0] = 1'b1;
      padr0_d = M0_RADR;
    end
    if (v1 && !(idle && sel)) begin
      pend_d[1] = 1'b1;
      padr1_d = M1_RADR;
    end
    if (idle && (c0 || c1)) pend_d[sel] = 1'b0;
  end
  // state registers; both last-grant registers reset to M1 so M0 wins the first tie
  always_ff @(posedge SYSCLK or negedge SYSRSTB) begin
    if (!SYSRSTB) begin
      st_q <= R_IDLE;
      pend_q <= '0;
      padr0_q <= '0;
      padr1_q <= '0;
      own_q <= 1'b0;
      rlast_q <= 1'b1;
      wlock_q <= 1'b0;
      wown_q <= 1'b0;
      wlast_q <= 1'b1;
    end else begin
      st_q <= st_d;
      pend_q <= pend_d;
      padr0_q <= padr0_d;
      padr1_q <= padr1_d;
      own_q <= own_d;
      rlast_q <= rlast_d;
      wlock_q <= wlock_d;
      wown_q <= wown_d;
      wlast_q <= wlast_d;
    end
  end
endmodule

// File: tb/tb_sc_scbc_rba.sv
// tb_sc_scbc_rba: randomized bench for sc_scbc_rba against a transaction-level reference model
module tb_sc_scbc_rba;
  logic SYSCLK = 1'b0;
  logic SYSRSTB = 1'b0;
  always #5 SYSCLK = ~SYSCLK;
  logic [1:0][31:0] m_wadr, m_wdat, m_radr, m_rdat;
  logic [1:0][3:0]  m_wenb;
  logic [1:0]       m_renb, m_wwat, m_werr, m_rwat, m_rerr;
  logic [31:0] s_wadr, s_wdat, s_radr, s_rdat;
  logic [3:0]  s_wenb;
  logic        s_wwat, s_werr, s_renb, s_rwat, s_rerr;
  sc_scbc_rba dut (
    .SYSCLK(SYSCLK), .SYSRSTB(SYSRSTB),
    .M0_WADR(m_wadr[0]), .M0_WDAT(m_wdat[0]), .M0_WENB(m_wenb[0]), .M0_WWAT(m_wwat[0]), .M0_WERR(m_werr[0]),
    .M0_RADR(m_radr[0]), .M0_RENB(m_renb[0]), .M0_RWAT(m_rwat[0]), .M0_RDAT(m_rdat[0]), .M0_RERR(m_rerr[0]),
    .M1_WADR(m_wadr[1]), .M1_WDAT(m_wdat[1]), .M1_WENB(m_wenb[1]), .M1_WWAT(m_wwat[1]), .M1_WERR(m_werr[1]),
    .M1_RADR(m_radr[1]), .M1_RENB(m_renb[1]), .M1_RWAT(m_rwat[1]), .M1_RDAT(m_rdat[1]), .M1_RERR(m_rerr[1]),
    .S_WADR(s_wadr), .S_WDAT(s_wdat), .S_WENB(s_wenb), .S_WWAT(s_wwat), .S_WERR(s_werr),
    .S_RADR(s_radr), .S_RENB(s_renb), .S_RWAT(s_rwat), .S_RDAT(s_rdat), .S_RERR(s_rerr)
  );
  int tests = 0;
  int fails = 0;
  // reference model: write owner under stall (-1 none), read owner (-1 idle), queued reads per master
  int wlock, wlast, rown, rlast, n_wlock, n_wlast, n_rown, n_rlast;
  bit rq[2], n_rq[2];
  logic [31:0] rad[2], n_rad[2];
  // master-side write transactions held until accepted
  bit wact[2];
  bit wwat_e[2];
  logic [31:0] wa[2], wd[2];
  logic [3:0] we[2];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    wlock = -1; wlast = 1; rown = -1; rlast = 1;
    for (int n = 0; n < 2; n++) begin
      rq[n] = 0; rad[n] = '0; wact[n] = 0; wwat_e[n] = 0;
    end
  endtask
  task automatic drive(input int c);
    int pw, pr, pil, psw, psr;
    pw = 100; pr = 100; pil = 0; psw = 0; psr = 0;
    if (c >= 200) begin psw = 40; psr = 50; end
    if (c >= 600) begin pw = 50; pr = 40; pil = 10; psw = 30; psr = 30; end
    for (int n = 0; n < 2; n++) begin
      if (!wact[n] && $urandom_range(99) < pw) begin
        wact[n] = 1; wa[n] = $urandom; wd[n] = $urandom; we[n] = 4'($urandom_range(15, 1));
      end
      if (c == 0) begin
        wact[n] = 1; wa[n] = n ? 32'h14 : 32'h10; wd[n] = n ? 32'h5A5A5A5A : 32'hA5A5A5A5; we[n] = 4'hF;
      end
      m_wenb[n] = wact[n] ? we[n] : 4'h0;
      m_wadr[n] = wact[n] ? wa[n] : $urandom;
      m_wdat[n] = wact[n] ? wd[n] : $urandom;
      m_renb[n] = (rq[n] || rown == n) ? ($urandom_range(99) < pil) : ($urandom_range(99) < pr);
      m_radr[n] = (c == 0) ? 32'(n * 4) : $urandom;
    end
    s_wwat = $urandom_range(99) < psw;
    s_werr = 1'($urandom);
    s_rwat = $urandom_range(99) < psr;
    s_rdat = $urandom;
    s_rerr = 1'($urandom);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_swenb"}, {s_wenb, s_wadr, s_wdat}, '0);
    check({tag, "_sren"}, {s_renb, s_radr}, '0);
    check({tag, "_wwat_werr"}, {m_wwat, m_werr}, '0);
    check({tag, "_rwat_rerr"}, {m_rwat, m_rerr}, '0);
    check({tag, "_rdat"}, m_rdat, '0);
  endtask
  task automatic eval_check();
    int g, sel;
    bit req[2], vs[2], cand[2];
    logic [31:0] e_wadr, e_wdat, e_radr;
    logic [3:0] e_wenb;
    logic [1:0] e_wwat, e_werr, e_rwat, e_rerr;
    logic [1:0][31:0] e_rdat;
    logic e_ren;
    for (int n = 0; n < 2; n++) req[n] = m_wenb[n] != 0;
    g = -1;
    if (wlock >= 0) g = wlock;
    else if (req[0] && req[1]) g = 1 - wlast;
    else if (req[0]) g = 0;
    else if (req[1]) g = 1;
    if (g >= 0 && !req[g]) g = -1;
    e_wadr = g < 0 ? '0 : m_wadr[g];
    e_wdat = g < 0 ? '0 : m_wdat[g];
    e_wenb = g < 0 ? '0 : m_wenb[g];
    for (int n = 0; n < 2; n++) begin
      e_wwat[n] = req[n] ? (g == n ? s_wwat : 1'b1) : 1'b0;
      e_werr[n] = g == n ? s_werr : 1'b0;
      wwat_e[n] = e_wwat[n];
    end
    n_wlock = (g >= 0 && s_wwat) ? g : -1;
    n_wlast = (g >= 0 && !s_wwat) ? g : wlast;
    e_ren = 0; e_radr = '0; e_rdat = '0; e_rerr = '0;
    n_rq = rq; n_rad = rad; n_rown = rown; n_rlast = rlast;
    for (int n = 0; n < 2; n++) begin
      vs[n] = m_renb[n] && !rq[n] && rown != n;
      e_rwat[n] = rq[n];
    end
    if (rown < 0) begin
      for (int n = 0; n < 2; n++) cand[n] = rq[n] || vs[n];
      if (cand[0] || cand[1]) begin
        sel = (cand[0] && cand[1]) ? 1 - rlast : (cand[1] ? 1 : 0);
        e_ren = 1;
        e_radr = rq[sel] ? rad[sel] : m_radr[sel];
        n_rown = sel;
        n_rq[sel] = 0;
        if (vs[1 - sel]) begin n_rq[1 - sel] = 1; n_rad[1 - sel] = m_radr[1 - sel]; end
      end
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (n == rown) e_rwat[n] = s_rwat;
        if (vs[n]) begin n_rq[n] = 1; n_rad[n] = m_radr[n]; end
      end
      if (!s_rwat) begin
        e_rdat[rown] = s_rdat;
        e_rerr[rown] = s_rerr;
        n_rown = -1;
        n_rlast = rown;
      end
    end
    check("s_wadr", s_wadr, e_wadr);
    check("s_wdat", s_wdat, e_wdat);
    check("s_wenb", s_wenb, e_wenb);
    check("wwat", m_wwat, e_wwat);
    check("werr", m_werr, e_werr);
    check("s_renb", s_renb, e_ren);
    check("s_radr", s_radr, e_radr);
    check("rwat", m_rwat, e_rwat);
    check("rdat0", m_rdat[0], e_rdat[0]);
    check("rdat1", m_rdat[1], e_rdat[1]);
    check("rerr", m_rerr, e_rerr);
  endtask
  task automatic commit();
    wlock = n_wlock; wlast = n_wlast; rown = n_rown; rlast = n_rlast; rq = n_rq; rad = n_rad;
    for (int n = 0; n < 2; n++) if (wact[n] && !wwat_e[n]) wact[n] = 0;
  endtask
  initial begin
    bit did_rst;
    did_rst = 0;
    model_reset();
    drive(1000);
    m_renb = 2'b11;
    #3 check_zero("rst");
    @(posedge SYSCLK);
    #1 SYSRSTB = 1'b1;
    for (int c = 0; c < 2000; c++) begin
      bit do_rst;
      do_rst = (!did_rst && c > 400 && rown >= 0 && rq[1]) || c == 1500;
      drive(c);
      #1;
      if (do_rst) begin
        did_rst = 1;
        SYSRSTB = 1'b0;
        #1 check_zero("midrst");
        model_reset();
        @(posedge SYSCLK);
        #1 check_zero("midrst_hold");
        @(posedge SYSCLK);
        #1 SYSRSTB = 1'b1;
      end else begin
        eval_check();
        @(posedge SYSCLK);
        commit();
        #1;
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sc_scbc_rba.md
# sc_scbc_rba

Register Bus Arbiter for the Space Communication Bus Controller. It shares the single register bus that feeds the slave access selector between two requesters: M0, the host system-bus bridge, and M1, the on-board command path. Write and read channels are arbitrated independently with round-robin fairness. The block holds a one-deep pending read per master, so single-cycle read strobes are never lost while the downstream channel is busy.

## Interface
- ADDR_WIDTH, 32, register address width on all ports.

Ports (Mn = M0 and M1, one instance per master):
- SYSCLK  in  1  system bus clock.
- SYSRSTB  in  1  asynchronous, active-low reset.
- Mn_WADR  in  ADDR_WIDTH  write address.
- Mn_WDAT  in  32  write data.
- Mn_WENB  in  4  write byte enables; non-zero means a write request.
- Mn_WWAT  out  1  write wait; master holds its request while this is 1.
- Mn_WERR  out  1  write error.
- Mn_RADR  in  ADDR_WIDTH  read address.
- Mn_RENB  in  1  read strobe, one cycle per read.
- Mn_RWAT  out  1  read wait.
- Mn_RDAT  out  32  read data.
- Mn_RERR  out  1  read error.
- S_WADR, S_WDAT, S_WENB  out  ADDR_WIDTH/32/4  downstream write.
- S_WWAT, S_WERR  in  1  downstream write wait and error.
- S_RADR  out  ADDR_WIDTH  downstream read address.
- S_RENB  out  1  downstream read strobe.
- S_RWAT, S_RDAT, S_RERR  in  1/32/1  downstream read wait, data and error.

## Operation
- Write channel:
  - A write request is Mn_WENB != 0.
  - The write grant is combinational. When one master requests, that master is granted. When both request, the master that was not granted last wins. The last-grant register resets to M1, so M0 wins the first tie.
  - The granted master's WADR, WDAT and WENB drive S_*. The loser sees Mn_WWAT = 1.
  - The granted master sees Mn_WWAT = S_WWAT and Mn_WERR = S_WERR.
  - A write completes on the cycle where S_WENB != 0 and S_WWAT = 0. On completion, last-grant is updated.
  - If S_WWAT = 1, a lock bit holds the grant on the current master until completion, even if the other master requests.
  - With no request, S_WENB = 0 and S_WADR/S_WDAT = 0.
- Read channel FSM:
  - R_IDLE:
    - The candidates are M0 and M1, each with Mn_RENB or pend[n] set. One candidate is selected round-robin, using a separate read last-grant register that resets to M1.
    - S_RENB = 1 for the selected master. S_RADR comes from its latched pending address if pend[n] is set, otherwise from Mn_RADR.
    - The owner is recorded and the FSM goes to R_WAIT. The pend bit of the selected master clears.
    - An unselected master with Mn_RENB = 1 has its pend bit set and Mn_RADR latched.
  - R_WAIT:
    - S_RENB = 0 throughout this state.
    - The owner sees Mn_RWAT = S_RWAT.
    - The data cycle is the first cycle with S_RWAT = 0. In that cycle the owner sees Mn_RDAT = S_RDAT and Mn_RERR = S_RERR. The FSM then goes to R_IDLE on the next cycle and last-grant is updated.
    - No new S_RENB is issued in the data cycle, because the downstream ignores a strobe there.
    - Any Mn_RENB seen in R_WAIT, including in the data cycle, sets pend[n].
- Each master has exactly one pending slot.
  - A master with pend[n] = 1, or that is the current owner, must not strobe again.
  - Such a strobe is ignored and has no effect on state.
- Mn_RWAT = 1 from the cycle after a master's strobe until its data cycle; Mn_RWAT is 0 in the data cycle itself.
- Mn_RDAT and Mn_RERR are 0 for every master outside its own data cycle.

## Timing
- Reset (asynchronous):
  - FSM goes to R_IDLE, pend = 00, write lock = 0, both last-grants = M1.
  - All outputs are 0: Mn_WWAT, Mn_WERR, Mn_RWAT, Mn_RDAT, Mn_RERR, and every S_* output.
  - Reset asserted mid-transaction aborts it; the downstream shares SYSRSTB.
- Write: zero added latency; the request passes combinationally to S_*.
- Read, uncontended:
  - Strobe at cycle t gives S_RENB at t, with no added latency.
  - With a sync slave, the data cycle is t+1.
  - The next issue is possible at t+2 or later.
- Read, contended: the loser is issued in the R_IDLE cycle after the winner's data cycle. For sync slaves that is t+2, with loser data at t+3.
- Read and write channels are fully independent; simultaneous activity on both is allowed.

## Test plan
- Simultaneous writes from reset, M0 to 0x10 with data 0xA5A5A5A5 and M1 to 0x14 with data 0x5A5A5A5A, all enables 0xF -> M0 writes in cycle 0 with M1_WWAT = 1; M1 writes in cycle 1.
- M0 write with S_WWAT held high for 3 cycles while M1 also requests -> grant stays on M0 for 4 cycles and M1_WWAT stays 1; M1 is granted in cycle 4.
- Simultaneous reads from reset, M0 at 0x00 and M1 at 0x04, sync slave -> S_RENB at t with M0's address and at t+2 with M1's address.
  - M0_RDAT valid at t+1; M1_RDAT valid at t+3.
  - M1_RWAT = 1 for t+1..t+2.
- M0 read to an async slave with S_RWAT = 1 for 5 cycles, and an M1 strobe during the wait -> M1 is issued in the R_IDLE cycle after M0's data cycle and receives its own data.
  - M0_RDAT is 0 throughout M1's data cycle.
- Alternating contention over 8 rounds -> grants alternate M0, M1, M0, ... on both channels.
- SYSRSTB asserted during R_WAIT with pend[1] = 1 -> all outputs 0 immediately.
  - After reset release, no stale S_RENB is issued.
